// File: rtl/mux_sel_arb_if.sv
// Handshake and data bundle between the requesters and the mux feeder.
// The feeder (slave side) returns grants, captured data and the mux selects.
interface mux_sel_arb_if #(
    parameter int WIDTH = 4
);
    logic [2:0]       req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [2:0]       gnt;
    logic [WIDTH-1:0] ip1;
    logic [WIDTH-1:0] ip2;
    logic [WIDTH-1:0] ip3;
    logic             sel1;
    logic             sel2;
    logic             sel3;
    logic             busy;

    modport master (
        output req, din0, din1, din2,
        input  gnt, ip1, ip2, ip3, sel1, sel2, sel3, busy
    );

    modport slave (
        input  req, din0, din1, din2,
        output gnt, ip1, ip2, ip3, sel1, sel2, sel3, busy
    );
endinterface

// File: rtl/mux_sel_arb.sv
// Round-robin feeder for the 3-input priority mux: captures the winner's word
// and holds exactly one select high for HOLD_CYCLES cycles per grant.
//
//   state | meaning
//   IDLE  | all selects low; arbitrate on the next edge if any req is set
//   HOLD  | one select high; hold timer counts down to terminal count 0
module mux_sel_arb #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    mux_sel_arb_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [1:0]       last_q;
    logic [2:0]       gnt_q;
    logic [2:0]       sel_q;
    logic [WIDTH-1:0] ip1_q;
    logic [WIDTH-1:0] ip2_q;
    logic [WIDTH-1:0] ip3_q;

    logic [2:0]       gnt_d;
    logic [1:0]       win_d;

    // Scan starts just after the last winner, so the last winner is checked last.
    always_comb begin
        gnt_d = 3'b000;
        case (last_q)
            2'd0: begin
                if (bus.req[1])      gnt_d = 3'b010;
                else if (bus.req[2]) gnt_d = 3'b100;
                else if (bus.req[0]) gnt_d = 3'b001;
            end
            2'd1: begin
                if (bus.req[2])      gnt_d = 3'b100;
                else if (bus.req[0]) gnt_d = 3'b001;
                else if (bus.req[1]) gnt_d = 3'b010;
            end
            default: begin
                if (bus.req[0])      gnt_d = 3'b001;
                else if (bus.req[1]) gnt_d = 3'b010;
                else if (bus.req[2]) gnt_d = 3'b100;
            end
        endcase
        win_d = gnt_d[2] ? 2'd2 : (gnt_d[1] ? 2'd1 : 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 2'd2;
            gnt_q   <= 3'b000;
            sel_q   <= 3'b000;
            ip1_q   <= '0;
            ip2_q   <= '0;
            ip3_q   <= '0;
        end else begin
            gnt_q <= 3'b000;
            unique case (state_q)
                IDLE: begin
                    if (gnt_d != 3'b000) begin
                        gnt_q   <= gnt_d;
                        sel_q   <= gnt_d;
                        cnt_q   <= HOLD_LOAD;
                        last_q  <= win_d;
                        state_q <= HOLD;
                        if (gnt_d[0]) ip1_q <= bus.din0;
                        if (gnt_d[1]) ip2_q <= bus.din1;
                        if (gnt_d[2]) ip3_q <= bus.din2;
                    end
                end
                HOLD: begin
                    // Requests are deliberately ignored here; they wait for IDLE.
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        sel_q   <= 3'b000;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel1 = sel_q[0];
    assign bus.sel2 = sel_q[1];
    assign bus.sel3 = sel_q[2];
    assign bus.ip1  = ip1_q;
    assign bus.ip2  = ip2_q;
    assign bus.ip3  = ip3_q;
    assign bus.busy = (state_q == HOLD);
endmodule

// File: tb/tb_mux_sel_arb.sv
// Bench for mux_sel_arb: HOLD_CYCLES=2 and HOLD_CYCLES=1 instances, a cycle model
// pushing expected grants at posedge and a negedge monitor popping them.
module tb_mux_sel_arb;
    localparam int W = 4;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    typedef struct packed {
        int                 left;
        int                 last;
        logic [2:0]         sel;
        logic [2:0][W-1:0]  ip;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_sel_arb_if #(.WIDTH(W)) bif ();
    mux_sel_arb_if #(.WIDTH(W)) bif1 ();

    mux_sel_arb #(.WIDTH(W), .HOLD_CYCLES(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    mux_sel_arb #(.WIDTH(W), .HOLD_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif1.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    mdl_t m0, m1;
    exp_t q0[$], q1[$];
    int   glog0[$], glog1[$];
    bit   p0, p1, has0, has1;
    exp_t e0, e1, x0, x1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: 'left' counts the select cycles still owed for the current grant.
    task automatic mdl_step(input int h, input logic rst, input logic [2:0] req,
                            input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, inout mdl_t m,
                            output bit push, output exp_t e);
        logic [2:0][W-1:0] d;
        int w;
        int c;
        d = {d2, d1, d0};
        push = 1'b0;
        e = '0;
        w = -1;
        if (!rst) begin
            m.left = 0;
            m.last = 2;
            m.sel  = 3'b000;
            m.ip   = '0;
        end else if (m.left > 0) begin
            m.left--;
            if (m.left == 0) m.sel = 3'b000;
        end else if (req != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                c = (m.last + k) % 3;
                if (w < 0 && req[c]) w = c;
            end
            m.left  = h;
            m.sel   = 3'(1 << w);
            m.ip[w] = d[w];
            m.last  = w;
            push    = 1'b1;
            e.src   = 2'(w);
            e.data  = d[w];
        end
    endtask

    task automatic mon(input string nm, input mdl_t m, input bit has, input exp_t e,
                       input logic [2:0] gnt, input logic s1, input logic s2,
                       input logic s3, input logic busy, input logic [W-1:0] i1,
                       input logic [W-1:0] i2, input logic [W-1:0] i3);
        logic [2:0][W-1:0] ip;
        ip = {i3, i2, i1};
        chk({nm, "_sel"}, {29'd0, s3, s2, s1}, {29'd0, m.sel});
        chk({nm, "_busy"}, {31'd0, busy}, {31'd0, m.left > 0});
        chk({nm, "_ip"}, 32'(ip), 32'(m.ip));
        chk({nm, "_onehot"}, {31'd0, $countones({s3, s2, s1}) <= 1}, 32'd1);
        if (has) begin
            chk({nm, "_gnt"}, {29'd0, gnt}, 32'(1 << e.src));
            chk({nm, "_gnt_data"}, 32'(ip[e.src]), 32'(e.data));
        end else begin
            chk({nm, "_gnt_idle"}, {29'd0, gnt}, 32'd0);
        end
    endtask

    function automatic int gidx(input logic [2:0] g);
        return g[2] ? 2 : (g[1] ? 1 : 0);
    endfunction

    always @(posedge clk) begin
        mdl_step(2, rst_n, bif.req, bif.din0, bif.din1, bif.din2, m0, p0, e0);
        mdl_step(1, rst_n, bif1.req, bif1.din0, bif1.din1, bif1.din2, m1, p1, e1);
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (p0) q0.push_back(e0);
            if (p1) q1.push_back(e1);
        end
    end

    always @(negedge clk) begin
        has0 = (q0.size() > 0);
        if (has0) x0 = q0.pop_front();
        has1 = (q1.size() > 0);
        if (has1) x1 = q1.pop_front();
        mon("h2", m0, has0, x0, bif.gnt, bif.sel1, bif.sel2, bif.sel3, bif.busy,
            bif.ip1, bif.ip2, bif.ip3);
        mon("h1", m1, has1, x1, bif1.gnt, bif1.sel1, bif1.sel2, bif1.sel3, bif1.busy,
            bif1.ip1, bif1.ip2, bif1.ip3);
        if (bif.gnt != 3'b000) glog0.push_back(gidx(bif.gnt));
        if (bif1.gnt != 3'b000) glog1.push_back(gidx(bif1.gnt));
    end

    task automatic wait_gnt0(input logic [2:0] exp, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bif.gnt == 3'b000 && n < budget);
        chk("gnt_wait", {29'd0, bif.gnt}, {29'd0, exp});
    endtask

    int rr_exp[4] = '{0, 1, 2, 0};
    int h1_exp[4] = '{0, 2, 0, 2};
    int n;

    initial begin
        rst_n     = 1'b0;
        bif.req   = 3'b111;
        bif.din0  = 4'hF;
        bif.din1  = 4'hF;
        bif.din2  = 4'hF;
        bif1.req  = 3'b000;
        bif1.din0 = 4'h0;
        bif1.din1 = 4'h0;
        bif1.din2 = 4'h0;

        repeat (2) @(negedge clk);
        chk("rst_gnt", {29'd0, bif.gnt}, 32'd0);
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("rst_ip", {20'd0, bif.ip3, bif.ip2, bif.ip1}, 32'd0);

        // Round-robin with all three held
        bif.din0 = 4'h1;
        bif.din1 = 4'h2;
        bif.din2 = 4'h3;
        glog0.delete();
        rst_n = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        chk("rr_count", {31'd0, glog0.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (i < glog0.size()) ? glog0[i] : 9, rr_exp[i]);
        bif.req = 3'b000;
        repeat (3) @(negedge clk);

        // Single request from source 1
        bif.din1 = 4'hA;
        bif.req  = 3'b010;
        wait_gnt0(3'b010, 5, n);
        chk("single_lat", n, 1);
        chk("single_sel2", {31'd0, bif.sel2}, 32'd1);
        chk("single_ip2", {28'd0, bif.ip2}, 32'hA);
        bif.req = 3'b000;
        @(negedge clk);
        chk("single_sel2_hold", {31'd0, bif.sel2}, 32'd1);
        @(negedge clk);
        chk("single_sel2_off", {31'd0, bif.sel2}, 32'd0);
        chk("single_ip2_keep", {28'd0, bif.ip2}, 32'hA);
        chk("single_ip1_keep", {28'd0, bif.ip1}, 32'h1);
        chk("single_ip3_keep", {28'd0, bif.ip3}, 32'h3);

        // Late request: req[2] rises during a source-0 hold
        bif.din0 = 4'h5;
        bif.req  = 3'b001;
        wait_gnt0(3'b001, 5, n);
        bif.req  = 3'b100;
        bif.din2 = 4'h9;
        wait_gnt0(3'b100, 6, n);
        chk("late_lat", n, 3);
        chk("late_sel3", {31'd0, bif.sel3}, 32'd1);
        chk("late_consumer_ip3", {28'd0, bif.ip3}, {28'd0, bif.din2});
        bif.req = 3'b000;
        repeat (2) @(negedge clk);

        // Reset during the second hold cycle of a source-1 grant
        bif.din1 = 4'h7;
        bif.req  = 3'b010;
        wait_gnt0(3'b010, 5, n);
        @(negedge clk);
        chk("mid_sel2_before", {31'd0, bif.sel2}, 32'd1);
        rst_n   = 1'b0;
        bif.req = 3'b011;
        @(negedge clk);
        chk("mid_sel2", {31'd0, bif.sel2}, 32'd0);
        chk("mid_ip2", {28'd0, bif.ip2}, 32'd0);
        chk("mid_busy", {31'd0, bif.busy}, 32'd0);
        rst_n = 1'b1;
        wait_gnt0(3'b001, 5, n);
        chk("mid_first_ip1", {28'd0, bif.ip1}, 32'h5);
        bif.req = 3'b000;
        repeat (3) @(negedge clk);

        // HOLD_CYCLES = 1 instance alternating between sources 0 and 2
        bif1.din0 = 4'h3;
        bif1.din2 = 4'hC;
        glog1.delete();
        bif1.req  = 3'b101;
        repeat (9) @(negedge clk);
        #1;
        chk("h1_count", {31'd0, glog1.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++)
            chk("h1_order", (i < glog1.size()) ? glog1[i] : 9, h1_exp[i]);
        bif1.req = 3'b000;
        repeat (3) @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mux_sel_arb.md
Name: mux_sel_arb

Overview:
Upstream feeder for the 3-input priority mux stage. Arbitrates three requesters round-robin and captures the winner's data word. Drives the mux's ip1/ip2/ip3 buses and sel1/sel2/sel3 lines so that at most one select is ever high, which keeps the downstream priority logic from masking any source. Holds each selection for a programmable number of cycles so the mux's registered output settles and can be checked.

Parameters:
WIDTH, 4, data width of each source and of ip1..ip3.
HOLD_CYCLES, 2, cycles each sel line stays high per grant; legal range 1..15.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
req  input  3  level request; req[k] belongs to source k (k = 0, 1, 2).
din0  input  WIDTH  source 0 data; stable while req[0] is high.
din1  input  WIDTH  source 1 data; stable while req[1] is high.
din2  input  WIDTH  source 2 data; stable while req[2] is high.
gnt  output  3  one-cycle one-hot grant pulse; acknowledges capture of din_k.
ip1  output  WIDTH  registered data for mux input 1; loaded from din0.
ip2  output  WIDTH  registered data for mux input 2; loaded from din1.
ip3  output  WIDTH  registered data for mux input 3; loaded from din2.
sel1  output  1  mux select 1; high while source 0 holds the grant.
sel2  output  1  mux select 2; high while source 1 holds the grant.
sel3  output  1  mux select 3; high while source 2 holds the grant.
busy  output  1  high exactly when any sel is high (state HOLD).

Behaviour:
- Reset (rst_n = 0 at a posedge):
  - outputs: sel1..3 = 0, gnt = 3'b000, ip1..3 = 0, busy = 0.
  - internal: state = IDLE, hold counter = 0, last-winner pointer = 2, so source 0 has first priority.
  - Reset overrides every other event in the same cycle, including mid-HOLD.
- State machine: two states, IDLE and HOLD.
- IDLE with req == 0: nothing changes; gnt = 0.
- IDLE with req != 0: the winner w is the first set req bit scanning (last+1) mod 3, (last+2) mod 3, last. At the posedge:
  - the ip register for w loads din_w; sel for w is set to 1;
  - gnt is set to the one-hot code for w;
  - the counter loads HOLD_CYCLES-1; last is set to w; state goes to HOLD.
- HOLD:
  - gnt returns to 0 after exactly one cycle; req is ignored.
  - counter != 0: decrement it; sel stays unchanged.
  - counter == 0: clear all sel lines and return to IDLE.
- Resulting timing:
  - a sel line is high for exactly HOLD_CYCLES cycles;
  - at least one IDLE cycle with all sel low separates consecutive grants;
  - grant latency from req rising (sampled in IDLE) to gnt/sel is 1 cycle.
- Non-selected ip registers hold their previous value; no ip register ever changes while its own sel is high.
- Invariant: sel1 + sel2 + sel3 <= 1 at every posedge and negedge.
- Requester protocol:
  - keep req and din stable until gnt[k] is seen, then drop req the following cycle;
  - if req is still high in the next IDLE, it re-arbitrates normally (no pending state is lost or duplicated);
  - a req that rises during HOLD is served at the next IDLE per round-robin order.
- Wrap-around: the pointer wraps from 2 back to 0; with all three requests held continuously the grant order is 0, 1, 2, 0, 1, ...
- busy is decoded from state only; it has no combinational path from req.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with req = 3'b111 and din0..2 = 4'hF -> gnt = 0, sel1..3 = 0, ip1..3 = 0, busy = 0 throughout. First grant after release goes to source 0.
- Single request: req = 3'b010, din1 = 4'hA -> gnt = 3'b010 for 1 cycle one edge later; sel2 = 1 and ip2 = 4'hA for 2 cycles; then sel2 = 0 while ip2 stays 4'hA; ip1 and ip3 unchanged.
- Round-robin: req = 3'b111 held, din0 = 1, din1 = 2, din2 = 3 -> grants in order 0, 1, 2, 0 with a 3-cycle period (2 HOLD + 1 IDLE); sel line values match ip1 = 1, ip2 = 2, ip3 = 3 respectively; a one-hot checker never fires.
- HOLD_CYCLES = 1 build: req = 3'b101 held -> sel1 and sel3 alternate with 1-cycle pulses every 2 cycles; gnt order 0, 2, 0, 2.
- Reset mid-HOLD: assert rst_n = 0 during the second HOLD cycle of a source-1 grant -> the next edge gives sel2 = 0, ip2 = 0, busy = 0; after release with req = 3'b011, source 0 wins first.
- Late request: req[2] rises during source-0 HOLD with req[1] low -> ignored until IDLE, then gnt = 3'b100 and sel3 = 1. Downstream-style check holds: when sampled at negedge with sel3 = 1, the mux consumer sees ip3 = din2.
